exe_stage: RTL and testbench

- Execute stage of the 5-stage pipeline, directly upstream of the memory stage.
- Takes decoded operands and control from the ID/EX register and computes the ALU result or effective address (N+rs for lw/sw).
- Registers the result and control into the EX/MEM outputs consumed by the memory stage.
- Multiply and divide run on an iterative 32-cycle unit that stalls upstream; all other ops complete in one cycle.

---
 rtl/exe_stage.sv | 263 ++++++++++++++++++++++++++
 tb/tb_exe_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier and
// restoring divider that stalls upstream while it runs. Results and control
// are registered into the EX/MEM outputs.
// Optional feature macro: FAST_MUL_EN (combinational single-cycle multiply;
// divide stays iterative).
module exe_stage #(
  parameter int WIDTH = 32,
  parameter int RDW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             nop,
  input  logic             flush,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] store_data,
  input  logic [RDW-1:0]   rd,
  input  logic             we,
  input  logic             wren,
  input  logic             lw,
  output logic             stall,
  output logic [WIDTH-1:0] cal_result,
  output logic [WIDTH-1:0] mem_content,
  output logic [RDW-1:0]   out_rd,
  output logic             out_we,
  output logic             out_wren,
  output logic             out_lw,
  output logic             out_nop,
  output logic             exc
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;

  logic [WIDTH-1:0] alu_res;
  logic             alu_exc;
  logic             is_div;
  logic             is_iter;
  logic [WIDTH-1:0] a_abs, b_abs;

  // Iterative unit registers: acc is the product accumulator or the division
  // remainder; mcand is the multiplicand or divisor; mplier is the multiplier
  // or the dividend that shifts into the quotient.
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic             op_div, res_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] acc_step, mcand_step, mplier_step;
  logic [WIDTH:0]   trial, trial_diff;
  logic [WIDTH-1:0] iter_mag, iter_res;
  logic             iter_exc;

  logic             start_iter, step_en, load_result, load_bubble;
  logic [WIDTH-1:0] res_next;
  logic             exc_next;

  assign is_div = (alu_op == OP_DIV);
`ifdef FAST_MUL_EN
  assign is_iter = is_div;
`else
  assign is_iter = is_div || (alu_op == OP_MUL);
`endif
  assign a_abs = opa[MSB] ? -opa : opa;
  assign b_abs = opb[MSB] ? -opb : opb;

  // Single-cycle ALU result and signed-overflow flag; unknown codes behave as add.
  always_comb begin
    alu_res = opa + opb;
    alu_exc = (opa[MSB] == opb[MSB]) && (alu_res[MSB] != opa[MSB]);
    case (alu_op)
      OP_SUB: begin
        alu_res = opa - opb;
        alu_exc = (opa[MSB] != opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_AND: begin
        alu_res = opa & opb;
        alu_exc = 1'b0;
      end
      OP_OR: begin
        alu_res = opa | opb;
        alu_exc = 1'b0;
      end
      OP_SLL: begin
        alu_res = opa << opb[4:0];
        alu_exc = 1'b0;
      end
      OP_SRA: begin
        alu_res = $signed(opa) >>> opb[4:0];
        alu_exc = 1'b0;
      end
`ifdef FAST_MUL_EN
      OP_MUL: begin
        alu_res = opa * opb;
        alu_exc = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  // One shift-add or restoring-subtract step, and the sign-corrected final value.
  always_comb begin
    trial      = {acc, mplier[MSB]};
    trial_diff = trial - {1'b0, mcand};
    if (op_div) begin
      mcand_step = mcand;
      if (!trial_diff[WIDTH]) begin
        acc_step    = trial_diff[WIDTH-1:0];
        mplier_step = {mplier[WIDTH-2:0], 1'b1};
      end else begin
        acc_step    = trial[WIDTH-1:0];
        mplier_step = {mplier[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step    = mplier[0] ? (acc + mcand) : acc;
      mcand_step  = mcand << 1;
      mplier_step = mplier >> 1;
    end
    iter_mag = op_div ? mplier_step : acc_step;
    iter_res = res_neg ? -iter_mag : iter_mag;
    if (op_div && div_zero) iter_res = '0;
    iter_exc = op_div && (div_zero || div_ovf);
  end

  // Next-state logic, stall, and what the output register loads this cycle.
  always_comb begin
    state_next  = state;
    count_next  = count;
    stall       = 1'b0;
    start_iter  = 1'b0;
    step_en     = 1'b0;
    load_result = 1'b0;
    load_bubble = 1'b0;
    res_next    = alu_res;
    exc_next    = alu_exc;
    case (state)
      IDLE: begin
        if (nop || flush) begin
          load_bubble = 1'b1;
        end else if (is_iter) begin
          stall       = 1'b1;
          start_iter  = 1'b1;
          load_bubble = 1'b1;
          state_next  = BUSY;
          count_next  = '0;
        end else begin
          load_result = 1'b1;
        end
      end
      BUSY: begin
        if (flush) begin
          load_bubble = 1'b1;
          state_next  = IDLE;
          count_next  = '0;
        end else begin
          step_en = 1'b1;
          if (count == LAST) begin
            load_result = 1'b1;
            res_next    = iter_res;
            exc_next    = iter_exc;
            state_next  = IDLE;
            count_next  = '0;
          end else begin
            stall       = 1'b1;
            load_bubble = 1'b1;
            count_next  = count + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
    if (reset) stall = 1'b0;
  end

  // State and iteration counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Iterative unit: latch magnitudes and flags at start, then step each BUSY cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      op_div   <= 1'b0;
      res_neg  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else if (start_iter) begin
      acc      <= '0;
      op_div   <= is_div;
      res_neg  <= opa[MSB] ^ opb[MSB];
      div_zero <= is_div && (opb == '0);
      div_ovf  <= is_div && (opa == MOST_NEG) && (opb == '1);
      if (is_div) begin
        mcand  <= b_abs;
        mplier <= a_abs;
      end else begin
        mcand  <= a_abs;
        mplier <= b_abs;
      end
    end else if (step_en) begin
      acc    <= acc_step;
      mcand  <= mcand_step;
      mplier <= mplier_step;
    end
  end

  // EX/MEM output register: a full result, a bubble, or the reset value.
  always_ff @(posedge clock) begin
    if (reset) begin
      cal_result  <= '0;
      mem_content <= '0;
      out_rd      <= '0;
      out_we      <= 1'b0;
      out_wren    <= 1'b0;
      out_lw      <= 1'b0;
      out_nop     <= 1'b1;
      exc         <= 1'b0;
    end else if (load_result) begin
      cal_result  <= res_next;
      mem_content <= store_data;
      out_rd      <= rd;
      out_we      <= we;
      out_wren    <= wren;
      out_lw      <= lw;
      out_nop     <= 1'b0;
      exc         <= exc_next;
    end else if (load_bubble) begin
      out_we      <= 1'b0;
      out_wren    <= 1'b0;
      out_lw      <= 1'b0;
      out_nop     <= 1'b1;
      exc         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: table of single-cycle vectors plus directed
// sequences for mul/div latency, flush abort and reset while busy.
module tb_exe_stage;

  logic        clock = 1'b0;
  logic        reset, nop, flush;
  logic [4:0]  alu_op;
  logic [31:0] opa, opb, store_data;
  logic [4:0]  rd;
  logic        we, wren, lw;
  logic        stall;
  logic [31:0] cal_result, mem_content;
  logic [4:0]  out_rd;
  logic        out_we, out_wren, out_lw, out_nop, exc;

  int errors = 0;
  int checks = 0;

  exe_stage #(.WIDTH(32), .RDW(5)) dut (
    .clock(clock), .reset(reset), .nop(nop), .flush(flush),
    .alu_op(alu_op), .opa(opa), .opb(opb), .store_data(store_data),
    .rd(rd), .we(we), .wren(wren), .lw(lw),
    .stall(stall), .cal_result(cal_result), .mem_content(mem_content),
    .out_rd(out_rd), .out_we(out_we), .out_wren(out_wren), .out_lw(out_lw),
    .out_nop(out_nop), .exc(exc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, sd;
    logic [4:0]  r;
    logic        w, wr, l, n;
    logic [31:0] e_res, e_mem;
    logic [4:0]  e_rd;
    logic        e_exc, e_we, e_wren, e_lw, e_nop;
  } vec_t;

  vec_t vecs[14];

  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] sd, input logic [4:0] r, input logic w,
                               input logic wr, input logic l, input logic n);
    alu_op = op; opa = a; opb = b; store_data = sd;
    rd = r; we = w; wren = wr; lw = l; nop = n;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Present an iterative op, count stall cycles, then check the completed result.
  task automatic runIter(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e_res, input logic e_exc,
                         input int e_cycles);
    int cycles;
    logic bubbles_ok;
    cycles = 0;
    bubbles_ok = 1'b1;
    applyStimulus(op, a, b, 32'h0000_0055, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    while (stall === 1'b1 && cycles < 200) begin
      cycles++;
      tick();
      if (out_nop !== 1'b1) bubbles_ok = 1'b0;
    end
    checkOutput({tag, "_stall_cycles"}, cycles, e_cycles);
    checkOutput({tag, "_bubbles"}, {31'd0, bubbles_ok}, 32'd1);
    tick();
    checkOutput({tag, "_result"}, cal_result, e_res);
    checkOutput({tag, "_exc"}, {31'd0, exc}, {31'd0, e_exc});
    checkOutput({tag, "_nop"}, {31'd0, out_nop}, 32'd0);
    checkOutput({tag, "_rd"}, {27'd0, out_rd}, 32'd7);
    checkOutput({tag, "_we"}, {31'd0, out_we}, 32'd1);
    checkOutput({tag, "_mem"}, mem_content, 32'h0000_0055);
    applyStimulus(5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int bad_out;
    int mul_cycles;

    vecs[0]  = '{5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                 32'h8000_0000, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'b00000, 32'h0000_0100, 32'h0000_0024, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                 32'h0000_0124, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{5'b00001, 32'h0000_0005, 32'h0000_0007, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0,
                 32'hFFFF_FFFE, 32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'b00001, 32'h8000_0000, 32'h0000_0001, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0,
                 32'h7FFF_FFFF, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'b00010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0,
                 32'hF000_F000, 32'h0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'b00011, 32'h0F0F_0000, 32'h0000_00F0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0,
                 32'h0F0F_00F0, 32'h0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{5'b00100, 32'h0000_0001, 32'h0000_0024, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0,
                 32'h0000_0010, 32'h0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{5'b00101, 32'h8000_0000, 32'h0000_001F, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0,
                 32'hFFFF_FFFF, 32'h0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'b00101, 32'h4000_0000, 32'h0000_0004, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0,
                 32'h0400_0000, 32'h0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{5'b01111, 32'h0000_0003, 32'h0000_0004, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0,
                 32'h0000_0007, 32'h0, 5'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{5'b00000, 32'h0000_0200, 32'hFFFF_FFFC, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0,
                 32'h0000_01FC, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{5'b00000, 32'h0000_0001, 32'h0000_0001, 32'h0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1,
                 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{5'b00000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0,
                 32'hFFFF_FFFE, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{5'b00001, 32'h0000_0000, 32'h8000_0000, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0,
                 32'h8000_0000, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Power-on reset
    reset = 1'b1;
    flush = 1'b0;
    applyStimulus(5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("reset_nop", {31'd0, out_nop}, 32'd1);
    checkOutput("reset_result", cal_result, 32'd0);
    checkOutput("reset_we", {31'd0, out_we}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;

    // Single-cycle table
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sd, vecs[i].r,
                    vecs[i].w, vecs[i].wr, vecs[i].l, vecs[i].n);
      #1;
      checkOutput($sformatf("vec%0d_stall", i), {31'd0, stall}, 32'd0);
      tick();
      checkOutput($sformatf("vec%0d_nop", i), {31'd0, out_nop}, {31'd0, vecs[i].e_nop});
      checkOutput($sformatf("vec%0d_we", i), {31'd0, out_we}, {31'd0, vecs[i].e_we});
      checkOutput($sformatf("vec%0d_wren", i), {31'd0, out_wren}, {31'd0, vecs[i].e_wren});
      checkOutput($sformatf("vec%0d_lw", i), {31'd0, out_lw}, {31'd0, vecs[i].e_lw});
      checkOutput($sformatf("vec%0d_exc", i), {31'd0, exc}, {31'd0, vecs[i].e_exc});
      if (!vecs[i].n) begin
        checkOutput($sformatf("vec%0d_result", i), cal_result, vecs[i].e_res);
        checkOutput($sformatf("vec%0d_mem", i), mem_content, vecs[i].e_mem);
        checkOutput($sformatf("vec%0d_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].e_rd});
      end
    end
    applyStimulus(5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Iterative multiply and divide
`ifdef FAST_MUL_EN
    mul_cycles = 0;
`else
    mul_cycles = 32;
`endif
    runIter("mul_neg7x6", 5'b00110, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFD6, 1'b0, mul_cycles);
    runIter("div_neg100by7", 5'b00111, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 1'b0, 32);
    runIter("div_5by0", 5'b00111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, 32);
    runIter("div_minbyneg1", 5'b00111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32);
    tick();

    // Flush an in-flight divide at count=10
    applyStimulus(5'b00111, 32'd1000, 32'd3, 32'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (11) tick();
    checkOutput("flush_busy_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush_stall_drop", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    checkOutput("flush_bubble_nop", {31'd0, out_nop}, 32'd1);
    checkOutput("flush_bubble_we", {31'd0, out_we}, 32'd0);
    applyStimulus(5'b00000, 32'd2, 32'd3, 32'h0000_ABCD, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("flush_add_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("flush_add_result", cal_result, 32'd5);
    checkOutput("flush_add_nop", {31'd0, out_nop}, 32'd0);
    applyStimulus(5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    bad_out = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_nop !== 1'b1 || stall !== 1'b0) bad_out++;
    end
    checkOutput("flush_no_escape", bad_out, 32'd0);

    // Reset held for two cycles in the middle of a divide
    applyStimulus(5'b00111, 32'hFFFF_FF9C, 32'd7, 32'h0000_1234, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    checkOutput("midreset_stall1", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("midreset_stall2", {31'd0, stall}, 32'd0);
    checkOutput("midreset_nop", {31'd0, out_nop}, 32'd1);
    checkOutput("midreset_result", cal_result, 32'd0);
    checkOutput("midreset_mem", mem_content, 32'd0);
    checkOutput("midreset_rd", {27'd0, out_rd}, 32'd0);
    checkOutput("midreset_ctrl", {28'd0, out_we, out_wren, out_lw, exc}, 32'd0);
    applyStimulus(5'b00000, 32'd10, 32'd20, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("postreset_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("postreset_result", cal_result, 32'd30);
    checkOutput("postreset_nop", {31'd0, out_nop}, 32'd0);
    checkOutput("postreset_rd", {27'd0, out_rd}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
